// File: rtl/axi_sram_slave.sv
// AXI-style SRAM slave: independent INCR read and write burst engines, one burst in flight per direction.
// Optional macro AXI_SLAVE_SLVERR_EN adds an address range check with SLVERR responses.
module axi_sram_slave #(
  parameter logic [31:0] MEM_BASE  = 32'h1c00_0000,
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int IW = $clog2(MEM_WORDS);

  typedef enum logic {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;

  logic [31:0] mem_q [MEM_WORDS];

  r_state_e    r_state_q;
  logic [3:0]  rid_q;
  logic [29:0] r_woff_q;
  logic [7:0]  r_cnt_q;

  w_state_e    w_state_q;
  logic [3:0]  bid_q;
  logic [29:0] w_woff_q;
  logic [7:0]  w_cnt_q;
  logic        w_stop_q;
  logic        w_err_q;

  // Word offsets are kept at full address width so the range check sees beats past the top.
  logic [31:0] ar_off, aw_off;
  assign ar_off = araddr - MEM_BASE;
  assign aw_off = awaddr - MEM_BASE;

  logic [IW-1:0] r_idx, w_idx;
  assign r_idx = r_woff_q[IW-1:0];
  assign w_idx = w_woff_q[IW-1:0];

  logic r_oor, w_oor;
`ifdef AXI_SLAVE_SLVERR_EN
  assign r_oor = (r_woff_q >= 30'(MEM_WORDS));
  assign w_oor = (w_woff_q >= 30'(MEM_WORDS));
`else
  assign r_oor = 1'b0;
  assign w_oor = 1'b0;
  logic unused_off_hi;
  assign unused_off_hi = ^{r_woff_q[29:IW], w_woff_q[29:IW]};
`endif

  logic unused_byte_lane;
  assign unused_byte_lane = ^{ar_off[1:0], aw_off[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      r_woff_q  <= '0;
      r_cnt_q   <= '0;
    end else begin
      case (r_state_q)
        R_IDLE: if (arvalid) begin
          rid_q     <= arid;
          r_woff_q  <= ar_off[31:2];
          r_cnt_q   <= arlen;
          r_state_q <= R_DATA;
        end
        R_DATA: if (rready) begin
          r_woff_q <= r_woff_q + 30'd1;
          r_cnt_q  <= r_cnt_q - 8'd1;
          if (r_cnt_q == 8'd0) r_state_q <= R_IDLE;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign arready = (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_DATA);
  assign rlast   = rvalid && (r_cnt_q == 8'd0);
  assign rid     = rid_q;
  assign rresp   = (rvalid && r_oor) ? 2'b10 : 2'b00;
  assign rdata   = r_oor ? 32'h0 : mem_q[r_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      bid_q     <= '0;
      w_woff_q  <= '0;
      w_cnt_q   <= '0;
      w_stop_q  <= 1'b0;
      w_err_q   <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: if (awvalid) begin
          bid_q     <= awid;
          w_woff_q  <= aw_off[31:2];
          w_cnt_q   <= awlen;
          w_stop_q  <= 1'b0;
          w_err_q   <= 1'b0;
          w_state_q <= W_DATA;
        end
        W_DATA: if (wvalid) begin
          // Beats beyond awlen are drained until wlast but never reach the array.
          if (!w_stop_q) begin
            w_woff_q <= w_woff_q + 30'd1;
            if (w_oor) w_err_q <= 1'b1;
            if (w_cnt_q == 8'd0) w_stop_q <= 1'b1;
            else                 w_cnt_q  <= w_cnt_q - 8'd1;
          end
          if (wlast) w_state_q <= W_RESP;
        end
        W_RESP: if (bready) w_state_q <= W_IDLE;
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign awready = (w_state_q == W_IDLE);
  assign wready  = (w_state_q == W_DATA);
  assign bvalid  = (w_state_q == W_RESP);
  assign bid     = bid_q;
  assign bresp   = {w_err_q, 1'b0};

  logic w_we;
  assign w_we = wready && wvalid && !w_stop_q && !w_oor;

  // NOTE: the storage array has no reset branch; only control state is cleared by rst.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem_q[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: stimulus tasks queue expected R/B responses, a monitor checks them.
module tb_axi_sram_slave;

  localparam logic [31:0] BASE  = 32'h1c00_0000;
  localparam int          WORDS = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  always #5 clk = ~clk;

  axi_sram_slave #(.MEM_BASE(BASE), .MEM_WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_exp_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  typedef logic [31:0] warr_t [16];
  typedef logic [3:0]  sarr_t [16];

  r_exp_t rd_q[$];
  b_exp_t b_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compares every presented beat (stalled or not) against the queue head; pops on handshake.
  always @(negedge clk) begin
    r_exp_t re;
    b_exp_t be;
    if (!rst) begin
      if (rvalid) begin
        if (rd_q.size() == 0) check("r_unexpected_beat", 1, 0);
        else begin
          re = rd_q[0];
          check("rid", rid, re.id);
          check("rdata", rdata, re.data);
          check("rresp", rresp, re.resp);
          check("rlast", rlast, re.last);
          if (rready) void'(rd_q.pop_front());
        end
      end
      if (bvalid) begin
        if (b_q.size() == 0) check("b_unexpected_resp", 1, 0);
        else begin
          be = b_q[0];
          check("bid", bid, be.id);
          check("bresp", bresp, be.resp);
          if (bready) void'(b_q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    rd_q.delete();
    b_q.delete();
  endtask

  task automatic write_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len_m1,
                             input int nbeats, input warr_t d, input sarr_t s,
                             input logic [1:0] exp_resp, input int hold);
    int t;
    b_q.push_back('{id: id, resp: exp_resp});
    bready  = (hold == 0);
    awid    = id;
    awaddr  = addr;
    awlen   = len_m1;
    awvalid = 1'b1;
    t = 0;
    while (!awready && t < 50) begin tick(); t++; end
    check("aw_accept", awready, 1);
    tick();
    awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      wvalid = 1'b1;
      wdata  = d[i];
      wstrb  = s[i];
      wlast  = (i == nbeats - 1);
      t = 0;
      while (!wready && t < 50) begin tick(); t++; end
      check("w_accept", wready, 1);
      tick();
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
    t = 0;
    while (!bvalid && t < 50) begin tick(); t++; end
    check("bvalid_up", bvalid, 1);
    for (int h = 0; h < hold; h++) begin
      check("bvalid_held", bvalid, 1);
      check("wready_in_resp", wready, 0);
      tick();
    end
    bready = 1'b1;
    t = 0;
    while (bvalid && t < 50) begin tick(); t++; end
    check("bvalid_drop", bvalid, 0);
  endtask

  task automatic read_burst(input logic [3:0] id, input logic [31:0] addr, input int len,
                            input warr_t d, input logic [1:0] resp, input bit toggle);
    int t;
    bit done;
    for (int i = 0; i < len; i++)
      rd_q.push_back('{id: id, data: d[i], resp: resp, last: (i == len - 1)});
    arid    = id;
    araddr  = addr;
    arlen   = 8'(len - 1);
    arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin tick(); t++; end
    check("ar_accept", arready, 1);
    tick();
    arvalid = 1'b0;
    check("rvalid_first", rvalid, 1);
    done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (toggle) rready = (c % 2 == 0);
      if (rvalid) check("arready_busy", arready, 0);
      if (rvalid && rready && rlast) done = 1'b1;
      tick();
    end
    check("r_burst_done", done, 1);
    rready = 1'b1;
    check("arready_after", arready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    warr_t d, e;
    sarr_t sf, s;
    int t;
    rst = 1'b0; arid = '0; araddr = '0; arlen = '0; arvalid = 1'b0; rready = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b1;
    sf = '{default: 4'hF};
    do_reset();

    check("rst_arready", arready, 1);
    check("rst_awready", awready, 1);
    check("rst_rvalid", rvalid, 0);
    check("rst_rlast", rlast, 0);
    check("rst_wready", wready, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_rid", rid, 0);
    check("rst_bid", bid, 0);
    check("rst_rresp", rresp, 0);
    check("rst_bresp", bresp, 0);

    // Basic 4-beat write then read back.
    d = '{default: '0};
    d[0] = 32'd1; d[1] = 32'd2; d[2] = 32'd3; d[3] = 32'd4;
    write_burst(4'h3, BASE, 8'd3, 4, d, sf, 2'b00, 0);
    read_burst(4'h5, BASE, 4, d, 2'b00, 1'b0);

    // Fill words 4..15, then stalled 8-beat read and a wrapping read.
    for (int i = 0; i < 12; i++) d[i] = 32'h1000_0000 + 32'(i + 4);
    write_burst(4'h1, BASE + 32'd16, 8'd11, 12, d, sf, 2'b00, 0);
    e = '{default: '0};
    for (int i = 0; i < 8; i++) e[i] = 32'h1000_0008 + 32'(i);
    read_burst(4'h2, BASE + 32'd32, 8, e, 2'b00, 1'b1);
    e[0] = 32'h1000_000E; e[1] = 32'h1000_000F; e[2] = 32'd1; e[3] = 32'd2;
    read_burst(4'h4, BASE + 32'd56, 4, e, 2'b00, 1'b0);

    // Byte-strobe merge on word 5.
    d[0] = 32'hAABB_CCDD;
    write_burst(4'h6, BASE + 32'd20, 8'd0, 1, d, sf, 2'b00, 0);
    d[0] = 32'h0000_1100;
    s = '{default: 4'h0};
    s[0] = 4'b0010;
    write_burst(4'h7, BASE + 32'd20, 8'd0, 1, d, s, 2'b00, 0);
    e[0] = 32'hAABB_11DD;
    read_burst(4'h8, BASE + 32'd20, 1, e, 2'b00, 1'b0);

    // awlen=0 with three W beats: only the first lands in the array.
    d[0] = 32'h66; d[1] = 32'h77; d[2] = 32'h88;
    write_burst(4'hB, BASE + 32'd24, 8'd0, 3, d, sf, 2'b00, 0);
    e[0] = 32'h66; e[1] = 32'h1000_0007; e[2] = 32'h1000_0008;
    read_burst(4'hC, BASE + 32'd24, 3, e, 2'b00, 1'b0);

    // Concurrent write (B held off 5 cycles) and read on distinct words.
    for (int i = 0; i < 4; i++) d[i] = 32'hC000_0000 + 32'(i);
    for (int i = 0; i < 4; i++) e[i] = 32'h1000_0008 + 32'(i);
    fork
      write_burst(4'h9, BASE, 8'd3, 4, d, sf, 2'b00, 5);
      read_burst(4'hA, BASE + 32'd32, 4, e, 2'b00, 1'b0);
    join

    // One word past the top of the array.
`ifdef AXI_SLAVE_SLVERR_EN
    e[0] = 32'h0;
    read_burst(4'hD, BASE + 32'(4 * WORDS), 1, e, 2'b10, 1'b0);
    d[0] = 32'hDEAD_BEEF;
    write_burst(4'hE, BASE + 32'(4 * WORDS), 8'd0, 1, d, sf, 2'b10, 0);
    e[0] = 32'hC000_0000;
    read_burst(4'hF, BASE, 1, e, 2'b00, 1'b0);
`else
    e[0] = 32'hC000_0000;
    read_burst(4'hD, BASE + 32'(4 * WORDS), 1, e, 2'b00, 1'b0);
`endif

    // Reset while beat 2 of a 4-beat read is presented.
    for (int i = 0; i < 4; i++)
      rd_q.push_back('{id: 4'h6, data: 32'hC000_0000 + 32'(i), resp: 2'b00, last: (i == 3)});
    arid = 4'h6; araddr = BASE; arlen = 8'd3; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 50) begin tick(); t++; end
    check("mid_ar_accept", arready, 1);
    tick();
    arvalid = 1'b0;
    rready  = 1'b1;
    tick();
    check("mid_beat2_valid", rvalid, 1);
    rst    = 1'b1;
    rready = 1'b0;
    tick();
    rst = 1'b0;
    rd_q.delete();
    check("mid_rst_rvalid", rvalid, 0);
    check("mid_rst_arready", arready, 1);
    check("mid_rst_rlast", rlast, 0);
    rready = 1'b1;
    e[0] = 32'hC000_0001; e[1] = 32'hC000_0002;
    read_burst(4'h7, BASE + 32'd4, 2, e, 2'b00, 1'b0);

    tick();
    check("rd_q_empty", rd_q.size(), 0);
    check("b_q_empty", b_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
